// File: rtl/hazard_ctrl.sv
// Purpose : pipeline hazard control; load-use/branch stalls, MDU occupancy, redirect flush.
// Latency : outputs are combinational from state, MDU count and current-cycle inputs.
// Backpr. : stalls freeze PC and IF/ID and inject a nop into ID/EX; a redirect flushes IF/ID.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ifid_rs, ifid_rt         source fields of the instruction in ID
//   id_uses_rt               ID instruction reads rt
//   id_branch, id_redirect   ID branch present / PC redirect this cycle
//   id_mdu_start             ID holds mult/div (starts an MDU operation)
//   id_mdu_use               ID holds an instruction that needs an idle MDU
//   idex_memread, idex_regwrite, idex_dst   EX instruction load flag, write flag, destination
//   pc_write, hold, IF_flush, idex_bubble   pipeline control outputs
//   mdu_busy                 MDU occupancy count is nonzero
module hazard_ctrl #(
   parameter int MDU_LAT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] ifid_rs,
   input  logic [4:0] ifid_rt,
   input  logic       id_uses_rt,
   input  logic       id_branch,
   input  logic       id_redirect,
   input  logic       id_mdu_start,
   input  logic       id_mdu_use,
   input  logic       idex_memread,
   input  logic       idex_regwrite,
   input  logic [4:0] idex_dst,
   output logic       pc_write,
   output logic       hold,
   output logic       IF_flush,
   output logic       idex_bubble,
   output logic       mdu_busy
);

   typedef enum logic {
      RUN    = 1'b0,
      STALL2 = 1'b1
   } state_t;

   state_t     r_state;
   logic [5:0] r_mcnt;

   logic w_dep;
   logic w_load_use;
   logic w_alu_br;
   logic w_mdu_hz;
   logic w_stall;

   // r0 is hardwired to zero, so a write to it never creates a dependency.
   assign w_dep = (idex_dst != 5'd0) &&
                  ((idex_dst == ifid_rs) || (id_uses_rt && (idex_dst == ifid_rt)));

   assign w_load_use = idex_memread && w_dep;
   // A branch compares in ID, so even an ALU result in EX is not yet forwardable to it.
   assign w_alu_br   = id_branch && idex_regwrite && !idex_memread && w_dep;
   assign w_mdu_hz   = id_mdu_use && (r_mcnt != 6'd0);

   // STALL2 covers the second bubble a branch needs behind a load.
   assign w_stall = (r_state == STALL2) || w_load_use || w_alu_br || w_mdu_hz;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
         r_mcnt  <= 6'd0;
      end else begin
         case (r_state)
            RUN:     r_state <= (w_load_use && id_branch) ? STALL2 : RUN;
            STALL2:  r_state <= RUN;
            default: r_state <= RUN;
         endcase

         // A stalled mult/div is re-presented next cycle, so only an issuing one loads.
         if (id_mdu_start && !w_stall) begin
            r_mcnt <= 6'(MDU_LAT);
         end else if (r_mcnt != 6'd0) begin
            r_mcnt <= r_mcnt - 6'd1;
         end
      end
   end

   always_comb begin
      pc_write    = 1'b1;
      hold        = 1'b0;
      IF_flush    = 1'b0;
      idex_bubble = 1'b0;
      mdu_busy    = (r_mcnt != 6'd0);
      if (rst) begin
         pc_write    = 1'b0;
         hold        = 1'b1;
         IF_flush    = 1'b1;
         idex_bubble = 1'b1;
         mdu_busy    = 1'b0;
      end else if (w_stall) begin
         // Redirect is ignored here; the branch re-resolves once the stall clears.
         pc_write    = 1'b0;
         hold        = 1'b1;
         idex_bubble = 1'b1;
      end else if (id_redirect) begin
         // IF/ID only honours flush while held.
         hold        = 1'b1;
         IF_flush    = 1'b1;
      end
   end

endmodule
